// File: rtl/f1_start_ctrl.sv
// F1 start-light timing controller: paces the light build-up, holds all lights
// for a pseudo-random number of ticks, then measures the driver's reaction time.
module f1_start_ctrl #(
    parameter int         TICK_CYCLES = 48,
    parameter logic [6:0] LFSR_SEED   = 7'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        react,
    input  logic [7:0]  lights_in,
    output logic        en,
    output logic        busy,
    output logic [15:0] reaction_time,
    output logic        time_valid,
    output logic        false_start
);

    localparam int            CW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUILD  = 2'd1,
        HOLD   = 2'd2,
        TIMING = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [6:0]     delay_cnt_q, delay_cnt_d;
    logic [15:0]    react_cnt_q, react_cnt_d;
    logic [6:0]     lfsr_q, lfsr_d;
    logic [15:0]    reaction_time_q, reaction_time_d;
    logic           time_valid_q, time_valid_d;
    logic           false_start_q, false_start_d;
    logic           tick;

    assign tick = (tick_cnt_q == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            delay_cnt_q     <= '0;
            react_cnt_q     <= '0;
            lfsr_q          <= LFSR_SEED;
            reaction_time_q <= '0;
            time_valid_q    <= 1'b0;
            false_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            delay_cnt_q     <= delay_cnt_d;
            react_cnt_q     <= react_cnt_d;
            lfsr_q          <= lfsr_d;
            reaction_time_q <= reaction_time_d;
            time_valid_q    <= time_valid_d;
            false_start_q   <= false_start_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick ? '0 : tick_cnt_q + 1'b1;
        delay_cnt_d     = delay_cnt_q;
        react_cnt_d     = react_cnt_q;
        // x^7 + x^6 + 1, free-running so the hold length depends on trigger timing
        lfsr_d          = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        reaction_time_d = reaction_time_q;
        time_valid_d    = 1'b0;
        false_start_d   = false_start_q;
        en              = 1'b0;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (trigger) begin
                    state_d       = BUILD;
                    false_start_d = 1'b0;
                end
            end

            BUILD: begin
                if (react) begin
                    false_start_d = 1'b1;
                end
                if (tick) begin
                    if (lights_in == 8'hFF) begin
                        state_d     = HOLD;
                        delay_cnt_d = lfsr_q;
                    end else begin
                        en = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (react) begin
                    false_start_d = 1'b1;
                end
                if (tick) begin
                    if (delay_cnt_q > 7'd1) begin
                        delay_cnt_d = delay_cnt_q - 7'd1;
                    end else begin
                        // lights out: the sequencer wraps S8 -> S0 on this strobe
                        en          = 1'b1;
                        state_d     = TIMING;
                        react_cnt_d = '0;
                    end
                end
            end

            TIMING: begin
                if (react) begin
                    reaction_time_d = react_cnt_q;
                    time_valid_d    = 1'b1;
                    state_d         = IDLE;
                end else if (react_cnt_q != 16'hFFFF) begin
                    react_cnt_d = react_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign reaction_time = reaction_time_q;
    assign time_valid    = time_valid_q;
    assign false_start   = false_start_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl: a light-sequencer model drives lights_in,
// expected en cycles and reaction times go to scoreboards popped by a monitor.
module tb_f1_start_ctrl;

    localparam int         T    = 4;
    localparam logic [6:0] SEED = 7'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        react = 1'b0;
    logic [7:0]  lights;
    logic        en;
    logic        busy;
    logic [15:0] reactionTime;
    logic        timeValid;
    logic        falseStart;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [6:0]  refLfsr;
    int          expEnQ[$];
    logic [15:0] expTimeQ[$];

    typedef struct {
        int          wantDelay;
        int          reactDelay;
        bit          reactInBuild;
        bit          reactInHold;
        bit          trigInBuild;
        logic [15:0] expTime;
        bit          expFalse;
    } runVec_t;

    runVec_t vecs[5];

    f1_start_ctrl #(.TICK_CYCLES(T), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger       (trigger),
        .react         (react),
        .lights_in     (lights),
        .en            (en),
        .busy          (busy),
        .reaction_time (reactionTime),
        .time_valid    (timeValid),
        .false_start   (falseStart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^7 + x^6 + 1, free-running from reset
    always @(posedge clk or posedge rst) begin
        if (rst) refLfsr <= SEED;
        else     refLfsr <= {refLfsr[5:0], refLfsr[6] ^ refLfsr[5]};
    end

    // Light sequencer model: each strobe lights one more lamp, strobe at all-lit clears
    always @(posedge clk or posedge rst) begin
        if (rst)     lights <= 8'h00;
        else if (en) lights <= (lights == 8'hFF) ? 8'h00 : {lights[6:0], 1'b1};
    end

    function automatic logic [6:0] lfsrAdvance(input logic [6:0] v, input int n);
        logic [6:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = {x[5:0], x[6] ^ x[5]};
        return x;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tickCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every en strobe and time_valid pulse must match a scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (en) begin
                if (expEnQ.size() == 0) checkOutput("unexpectedEn", cyc, -1);
                else                    checkOutput("enCycle", cyc, expEnQ.pop_front());
            end
            if (timeValid) begin
                if (expTimeQ.size() == 0) checkOutput("unexpectedTimeValid", cyc, -1);
                else                      checkOutput("reactionTime", reactionTime, expTimeQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input runVec_t v);
        int c0, d, cLo, press, waitN;
        waitN = 0;
        if (v.wantDelay != 0) begin
            while (int'(lfsrAdvance(refLfsr, 9 * T)) != v.wantDelay && waitN < 200) begin
                tickCycle();
                waitN++;
            end
        end
        trigger = 1'b1;
        c0 = cyc;
        d = int'(lfsrAdvance(refLfsr, 9 * T));
        for (int k = 1; k <= 8; k++) expEnQ.push_back(c0 + k * T);
        cLo = c0 + 9 * T + d * T;
        expEnQ.push_back(cLo);
        press = cLo + 1 + v.reactDelay;
        tickCycle();
        trigger = 1'b0;
        checkOutput("busyAfterTrigger", busy, 1);
        checkOutput("falseStartCleared", falseStart, 0);
        while (cyc < press) begin
            react   = (v.reactInBuild && cyc == c0 + 2) || (v.reactInHold && cyc == c0 + 9 * T + 2);
            trigger = v.trigInBuild && cyc == c0 + 5;
            tickCycle();
        end
        trigger = 1'b0;
        react = 1'b1;
        expTimeQ.push_back(v.expTime);
        tickCycle();
        react = 1'b0;
        checkOutput("busyAfterPress", busy, 0);
        checkOutput("falseStart", falseStart, v.expFalse);
        checkOutput("lightsOut", lights, 0);
        tickCycle();
        checkOutput("timeValidSingle", timeValid, 0);
        checkOutput("reactionTimeHeld", reactionTime, v.expTime);
        checkOutput("enQueueDrained", expEnQ.size(), 0);
        checkOutput("timeQueueDrained", expTimeQ.size(), 0);
    endtask

    task automatic midRunReset();
        int c0;
        trigger = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 8; k++) expEnQ.push_back(c0 + k * T);
        tickCycle();
        trigger = 1'b0;
        while (cyc < c0 + 9 * T + 3) tickCycle();
        checkOutput("busyInHold", busy, 1);
        #3 rst = 1'b1;
        #1;
        checkOutput("rstEn", en, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTimeValid", timeValid, 0);
        checkOutput("rstReactionTime", reactionTime, 0);
        checkOutput("rstFalseStart", falseStart, 0);
        checkOutput("rstBuildEnCount", expEnQ.size(), 0);
        expEnQ.delete();
        expTimeQ.delete();
        tickCycle();
        tickCycle();
        rst = 1'b0;
        tickCycle();
        checkOutput("idleAfterRst", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // wantDelay, reactDelay, reactInBuild, reactInHold, trigInBuild, expTime, expFalse
        vecs[0] = '{3,     37, 1'b0, 1'b0, 1'b0, 16'd37,   1'b0};
        vecs[1] = '{0,      0, 1'b1, 1'b0, 1'b0, 16'd0,    1'b1};
        vecs[2] = '{1,      5, 1'b0, 1'b1, 1'b1, 16'd5,    1'b1};
        vecs[3] = '{127,    1, 1'b0, 1'b0, 1'b0, 16'd1,    1'b0};
        vecs[4] = '{1,  70000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0};

        repeat (3) tickCycle();
        checkOutput("resetEn", en, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetReactionTime", reactionTime, 0);
        checkOutput("resetTimeValid", timeValid, 0);
        checkOutput("resetFalseStart", falseStart, 0);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tickCycle();
            checkOutput("idleBusy", busy, 0);
            checkOutput("idleEn", en, 0);
        end
        checkOutput("idleReactionTime", reactionTime, 0);

        for (int i = 0; i < 5; i++) begin
            if (i == 4) midRunReset();
            applyStimulus(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
Timing controller for the F1 start-light sequencer. It generates the one-cycle `en` strobe that advances the light FSM, one tick per light during build-up. Once all eight lights are lit, it holds them for a pseudo-random number of ticks, then issues the lights-out strobe. It then measures driver reaction time in clock cycles until the `react` button is pressed.

Parameters:
TICK_CYCLES, 48, clock cycles per tick (must be >= 2)
LFSR_SEED, 7'h01, reset value of the 7-bit random-delay LFSR (must be non-zero)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
trigger  input  1  start request, level-sampled, honoured only in IDLE
react  input  1  driver button, level-sampled
lights_in  input  8  light pattern from the sequencer (8'hFF = all lit)
en  output  1  one-cycle advance strobe to the light sequencer
busy  output  1  high in any state other than IDLE
reaction_time  output  16  last measured reaction time, in cycles
time_valid  output  1  one-cycle pulse when reaction_time updates
false_start  output  1  sticky flag: react was seen during BUILD or HOLD

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset state: FSM=IDLE, tick counter=0, delay_cnt=0, react counter=0, lfsr=LFSR_SEED.
- Output reset values: en=0, busy=0, reaction_time=0, time_valid=0, false_start=0.
- LFSR: 7-bit Fibonacci, taps x^7+x^6+1 (maximal length, 127 states), advances every cycle in all states. It never reaches 0.
- Tick: tick counter runs 0..TICK_CYCLES-1 and wraps. `tick`=1 when count==TICK_CYCLES-1. The counter is cleared on entry to BUILD.
- IDLE:
  - trigger=1 -> BUILD.
  - Clear false_start and the tick counter in the same cycle.
  - react is ignored.
- BUILD:
  - en = tick (combinational, registered-state-based).
  - If lights_in==8'hFF at a tick: go to HOLD, load delay_cnt <= lfsr (1..127), and en=0 on that tick.
  - If lights_in is not 8'hFF at a tick: en=1 and stay in BUILD.
- HOLD:
  - On each tick with delay_cnt>1: delay_cnt decrements.
  - On the tick with delay_cnt==1: en=1 (sequencer goes S8->S0, lights out), go to TIMING, clear the react counter.
- TIMING:
  - Each cycle with react=0: counter++, saturating at 16'hFFFF (no wrap).
  - Cycle with react=1: reaction_time <= counter, time_valid=1 next cycle for exactly one cycle, then -> IDLE.
  - A press in the first TIMING cycle yields 0.
- false_start: react=1 in any BUILD/HOLD cycle sets false_start. It stays set through TIMING and IDLE until the next accepted trigger. The sequence is not aborted.
- Ignored inputs: trigger outside IDLE has no effect. Holding trigger high restarts immediately on return to IDLE.
- en timing: en is only ever high for single cycles, and never in IDLE or TIMING.
- Reset mid-operation: rst in any state returns all state and outputs to reset values within the same cycle (async). The sequencer shares rst, so both restart together.
- Latency:
  - trigger accepted -> first en = TICK_CYCLES cycles later.
  - Full run = 9 build ticks + delay ticks.

Test Plan:
1. Reset then idle: rst pulse, trigger=0 for 200 cycles -> en never high, busy=0, all outputs 0.
2. Build-up, TICK_CYCLES=4 with the sequencer attached: trigger 1 cycle -> en pulses every 4 cycles, 8 pulses give lights_in 8'h01..8'hFF. The next tick does not pulse and enters HOLD with delay_cnt=lfsr.
3. Lights-out and timing: force lfsr seed so delay_cnt=3 -> 3 ticks after HOLD entry, en=1 and lights go 0. react asserted 37 cycles after TIMING entry -> reaction_time=37, time_valid single pulse, busy drops.
4. False start: react=1 during BUILD -> false_start=1, sequence completes normally. The next trigger clears false_start.
5. Saturation: no react for 70000 cycles in TIMING -> reaction_time reads 16'hFFFF after the press.
6. Mid-run reset: rst asserted in HOLD between clock edges -> en=0, busy=0, lfsr=LFSR_SEED immediately. The next trigger starts a fresh build.
